// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one syn_fifo write port among NREQ valid/ready producers.
// Registered write stage; a local credit count keeps writes off a full FIFO.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = $clog2(NREQ),
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       fifo_wr_en,
  output logic [DATA_WIDTH-1:0]      fifo_w_data,
  input  logic                       fifo_pop,
  input  logic                       fifo_overflow,
  output logic [ID_WIDTH-1:0]        grant_id,
  output logic [CNT_WIDTH-1:0]       level,
  output logic                       ovf_err
);

  logic [ID_WIDTH-1:0]   ptr_q;
  logic [CNT_WIDTH-1:0]  level_q, level_d;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  ovf_q;

  logic [DATA_WIDTH-1:0] words [NREQ];
  logic [ID_WIDTH-1:0]   idx, win;
  logic                  found, can_acc, acc;

  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the last winner so every requester rotates to the front.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = ID_WIDTH'((32'(ptr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // A pop this cycle only frees credit from the next cycle on.
  assign can_acc   = level_q < CNT_WIDTH'(DEPTH);
  assign acc       = rst & can_acc & found;
  assign req_ready = acc ? (NREQ'(1) << win) : '0;

  always_comb begin
    level_d = level_q;
    if (acc && !fifo_pop) begin
      level_d = level_q + CNT_WIDTH'(1);
    end else if (!acc && fifo_pop && level_q != '0) begin
      level_d = level_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= ID_WIDTH'(NREQ - 1);
      level_q  <= '0;
      wr_en_q  <= 1'b0;
      w_data_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_en_q <= acc;
      if (acc) begin
        w_data_q <= words[win];
        ptr_q    <= win;
      end
      level_q <= level_d;
      ovf_q   <= ovf_q | fifo_overflow;
    end
  end

  // The pointer always equals the last accepted id, so it doubles as grant_id.
  assign grant_id    = ptr_q;
  assign level       = level_q;
  assign fifo_wr_en  = wr_en_q;
  assign fifo_w_data = w_data_q;
  assign ovf_err     = ovf_q;

endmodule
